// File: rtl/rgb_csc_stage.sv
// Frame-level YUV 4:4:4 to RGB colour-space conversion stage working out of a shared SRAM.
// Each pixel pair is read, converted and written back in a fixed 9-cycle schedule.
module rgb_csc_stage #(
  parameter logic [17:0] Y_BASE    = 18'd0,
  parameter logic [17:0] U_BASE    = 18'd38400,
  parameter logic [17:0] V_BASE    = 18'd76800,
  parameter logic [17:0] RGB_BASE  = 18'd146944,
  parameter logic [17:0] NUM_PAIRS = 18'd38400
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD_Y   = 4'd1,
    S_RD_U   = 4'd2,
    S_RD_V   = 4'd3,
    S_WAIT_U = 4'd4,
    S_WAIT_V = 4'd5,
    S_CALC   = 4'd6,
    S_WR_0   = 4'd7,
    S_WR_1   = 4'd8,
    S_WR_2   = 4'd9,
    S_DONE   = 4'd10
  } state_t;

  // Saturate a fixed-point channel sum (16 fractional bits) into 0..255.
  function automatic logic [7:0] sat8(input logic signed [31:0] sum);
    logic signed [31:0] shifted;
    shifted = sum >>> 16;
    if (sum < 32'sd0) begin
      return 8'd0;
    end else if (shifted > 32'sd255) begin
      return 8'd255;
    end else begin
      return shifted[7:0];
    end
  endfunction

  // One pixel converted and packed as {R, G, B}.
  function automatic logic [23:0] csc_pixel(input logic [7:0] y, input logic [7:0] u,
                                            input logic [7:0] v);
    logic signed [31:0] yc, uc, vc, r, g, b;
    yc = $signed({24'd0, y}) - 32'sd16;
    uc = $signed({24'd0, u}) - 32'sd128;
    vc = $signed({24'd0, v}) - 32'sd128;
    r  = 32'sd76284 * yc + 32'sd104595 * vc;
    g  = 32'sd76284 * yc - 32'sd25624 * uc - 32'sd53281 * vc;
    b  = 32'sd76284 * yc + 32'sd132251 * uc;
    return {sat8(r), sat8(g), sat8(b)};
  endfunction

  state_t      state_q, state_d;
  logic [17:0] k_q, k_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d;
  logic [15:0] y_q, y_d, u_q, u_d, v_q, v_d;
  logic [23:0] rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic [23:0] pix0_s, pix1_s;
  logic [17:0] rgb_addr_s;

  assign pix0_s = csc_pixel(y_q[15:8], u_q[15:8], v_q[15:8]);
  assign pix1_s = csc_pixel(y_q[7:0],  u_q[7:0],  v_q[7:0]);

  // Next-state, datapath capture and next SRAM bus values (outputs are registered).
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    y_d     = y_q;
    u_d     = u_q;
    v_d     = v_q;
    rgb0_d  = rgb0_q;
    rgb1_d  = rgb1_q;
    addr_d  = 18'd0;
    we_n_d  = 1'b1;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          k_d     = 18'd0;
          busy_d  = 1'b1;
          state_d = S_RD_Y;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_Y:   state_d = S_RD_U;
      S_RD_U:   state_d = S_RD_V;
      S_RD_V: begin
        y_d     = SRAM_read_data;
        state_d = S_WAIT_U;
      end
      S_WAIT_U: begin
        u_d     = SRAM_read_data;
        state_d = S_WAIT_V;
      end
      S_WAIT_V: begin
        v_d     = SRAM_read_data;
        state_d = S_CALC;
      end
      S_CALC: begin
        rgb0_d  = pix0_s;
        rgb1_d  = pix1_s;
        state_d = S_WR_0;
      end
      S_WR_0:   state_d = S_WR_1;
      S_WR_1:   state_d = S_WR_2;
      S_WR_2: begin
        if (k_q < NUM_PAIRS - 18'd1) begin
          k_d     = k_q + 18'd1;
          state_d = S_RD_Y;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus values are keyed on the state being entered so they appear with it.
    case (state_d)
      S_RD_Y: addr_d = Y_BASE + k_d;
      S_RD_U: addr_d = U_BASE + k_d;
      S_RD_V: addr_d = V_BASE + k_d;
      S_WR_0: begin
        addr_d  = rgb_addr_s;
        we_n_d  = 1'b0;
        wdata_d = rgb0_d[23:8];
      end
      S_WR_1: begin
        addr_d  = rgb_addr_s + 18'd1;
        we_n_d  = 1'b0;
        wdata_d = {rgb0_d[7:0], rgb1_d[23:16]};
      end
      S_WR_2: begin
        addr_d  = rgb_addr_s + 18'd2;
        we_n_d  = 1'b0;
        wdata_d = rgb1_d[15:0];
      end
      S_DONE: done_d = 1'b1;
      default: addr_d = 18'd0;
    endcase
  end

  assign rgb_addr_s = RGB_BASE + k_d * 18'd3;

  // State, counter, datapath and output registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      k_q     <= 18'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= 18'd0;
      wdata_q <= 16'd0;
      we_n_q  <= 1'b1;
      y_q     <= 16'd0;
      u_q     <= 16'd0;
      v_q     <= 16'd0;
      rgb0_q  <= 24'd0;
      rgb1_q  <= 24'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      y_q     <= y_d;
      u_q     <= u_d;
      v_q     <= v_d;
      rgb0_q  <= rgb0_d;
      rgb1_q  <= rgb1_d;
    end
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign Busy            = busy_q;
  assign Done            = done_q;

endmodule

// File: tb/tb_rgb_csc_stage.sv
// Self-checking bench for rgb_csc_stage: SRAM model with 2-cycle read latency,
// frame-level reference model, fixed/random frames, Start filtering and mid-write reset.
module tb_rgb_csc_stage;

  localparam logic [17:0] YB  = 18'd0;
  localparam logic [17:0] UB  = 18'd100;
  localparam logic [17:0] VB  = 18'd200;
  localparam logic [17:0] RB  = 18'd262132;  // last write lands on 262143
  localparam logic [17:0] NP  = 18'd4;
  localparam int          NW  = 12;
  localparam int          LAT = 37;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic [15:0] SRAM_read_data = 16'd0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        Busy;
  logic        Done;

  int tests_run = 0;
  int tests_failed = 0;

  rgb_csc_stage #(
    .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .RGB_BASE(RB), .NUM_PAIRS(NP)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .SRAM_read_data(SRAM_read_data),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .Busy(Busy), .Done(Done)
  );

  always #10 Clock = ~Clock;

  logic [15:0] mem [int];
  logic [15:0] rd_pipe = 16'd0;
  logic [33:0] wlog [$];
  logic [15:0] expq [$];

  function automatic logic [15:0] memrd(input logic [17:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 16'h0000;
  endfunction

  // SRAM: address seen at end of cycle n, data presented through cycle n+2.
  always @(posedge Clock) begin
    rd_pipe        <= memrd(SRAM_address);
    SRAM_read_data <= rd_pipe;
    if (Resetn === 1'b1 && SRAM_we_n === 1'b0) begin
      wlog.push_back({SRAM_address, SRAM_write_data});
    end
  end

  function automatic logic [7:0] chan(input int s);
    int t;
    if (s < 0) t = 0;
    else begin
      t = s >>> 16;
      if (t > 255) t = 255;
    end
    return t[7:0];
  endfunction

  function automatic logic [23:0] ref_pixel(input int y, input int u, input int v);
    int r, g, b;
    r = 76284 * (y - 16) + 104595 * (v - 128);
    g = 76284 * (y - 16) - 25624 * (u - 128) - 53281 * (v - 128);
    b = 76284 * (y - 16) + 132251 * (u - 128);
    return {chan(r), chan(g), chan(b)};
  endfunction

  task automatic build_expected();
    logic [15:0] yw, uw, vw;
    logic [23:0] p0, p1;
    expq.delete();
    for (int k = 0; k < int'(NP); k++) begin
      yw = memrd(YB + 18'(k));
      uw = memrd(UB + 18'(k));
      vw = memrd(VB + 18'(k));
      p0 = ref_pixel(int'(yw[15:8]), int'(uw[15:8]), int'(vw[15:8]));
      p1 = ref_pixel(int'(yw[7:0]),  int'(uw[7:0]),  int'(vw[7:0]));
      expq.push_back({p0[23:16], p0[15:8]});
      expq.push_back({p0[7:0],   p1[23:16]});
      expq.push_back({p1[15:8],  p1[7:0]});
    end
  endtask

  // Pulse Start, count cycles to Done, then optionally poke Start during the Done cycle.
  task automatic run_frame(input bit extra_start, input bit start_at_done, output int cyc,
                           output bit busy_dropped, output bit done_after,
                           output bit busy_after);
    wlog.delete();
    busy_dropped = 1'b0;
    @(negedge Clock);
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    cyc = 1;
    while (Done !== 1'b1 && cyc < 200) begin
      if (Busy !== 1'b1) busy_dropped = 1'b1;
      Start = (extra_start && cyc == 10) ? 1'b1 : 1'b0;
      @(posedge Clock);
      #1;
      cyc++;
    end
    Start = start_at_done;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    done_after = Done;
    busy_after = Busy;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    Start  = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    tests_run++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: Busy=%b Done=%b, required 0 0", Busy, Done);
    end
    tests_run++;
    if (SRAM_we_n !== 1'b1 || SRAM_address !== 18'd0 || SRAM_write_data !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_bus: we_n=%b addr=%0d wdata=%h, required 1 0 0000",
               SRAM_we_n, SRAM_address, SRAM_write_data);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    wlog.delete();
    repeat (20) @(posedge Clock);
    #1;
    tests_run++;
    if (wlog.size() != 0 || Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: writes=%0d Busy=%b, required 0 0", wlog.size(), Busy);
    end
  endtask

  task automatic test_fixed_vectors();
    logic [15:0] fy [4] = '{16'h1010, 16'hEB10, 16'hFFFF, 16'h1010};
    logic [15:0] fu [4] = '{16'h8080, 16'h8080, 16'h8080, 16'h8080};
    logic [15:0] fv [4] = '{16'h8080, 16'h8080, 16'h8080, 16'h0000};
    logic [15:0] fexp [12] = '{16'h0000, 16'h0000, 16'h0000, 16'hFEFE, 16'hFE00, 16'h0000,
                               16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0068, 16'h0000, 16'h6800};
    int cyc;
    bit bd, da, ba;
    for (int k = 0; k < 4; k++) begin
      mem[int'(YB) + k] = fy[k];
      mem[int'(UB) + k] = fu[k];
      mem[int'(VB) + k] = fv[k];
    end
    run_frame(1'b1, 1'b0, cyc, bd, da, ba);
    tests_run++;
    if (cyc != LAT) begin
      tests_failed++;
      $display("FAIL fixed_latency: Done after %0d cycles, required %0d", cyc, LAT);
    end
    tests_run++;
    if (bd || da !== 1'b0 || ba !== 1'b0) begin
      tests_failed++;
      $display("FAIL fixed_handshake: busy_dropped=%b done_after=%b busy_after=%b, required 0 0 0",
               bd, da, ba);
    end
    tests_run++;
    if (wlog.size() != NW) begin
      tests_failed++;
      $display("FAIL fixed_write_count: %0d writes, required %0d", wlog.size(), NW);
    end
    for (int i = 0; i < NW && i < wlog.size(); i++) begin
      tests_run++;
      if (wlog[i] !== {RB + 18'(i), fexp[i]}) begin
        tests_failed++;
        $display("FAIL fixed_write[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                 i, wlog[i][33:16], wlog[i][15:0], RB + 18'(i), fexp[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    int cyc;
    bit bd, da, ba;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < int'(NP); k++) begin
        mem[int'(YB) + k] = 16'($urandom);
        mem[int'(UB) + k] = 16'($urandom);
        mem[int'(VB) + k] = 16'($urandom);
      end
      build_expected();
      run_frame(1'b0, 1'b0, cyc, bd, da, ba);
      tests_run++;
      if (cyc != LAT || wlog.size() != NW) begin
        tests_failed++;
        $display("FAIL random_frame%0d_shape: cycles=%0d writes=%0d, required %0d %0d",
                 f, cyc, wlog.size(), LAT, NW);
      end
      for (int i = 0; i < NW && i < wlog.size(); i++) begin
        tests_run++;
        if (wlog[i] !== {RB + 18'(i), expq[i]}) begin
          tests_failed++;
          $display("FAIL random_frame%0d_write[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                   f, i, wlog[i][33:16], wlog[i][15:0], RB + 18'(i), expq[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit bd, da, ba;
    build_expected();
    run_frame(1'b0, 1'b1, cyc, bd, da, ba);
    tests_run++;
    if (cyc != LAT || ba !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_in_done: cycles=%0d busy_after=%b, required %0d 0", cyc, ba, LAT);
    end
    repeat (12) @(posedge Clock);
    #1;
    tests_run++;
    if (wlog.size() != NW || Busy !== 1'b0 || SRAM_address !== 18'd0) begin
      tests_failed++;
      $display("FAIL start_in_done_ignored: writes=%0d Busy=%b addr=%0d, required %0d 0 0",
               wlog.size(), Busy, SRAM_address, NW);
    end
    run_frame(1'b0, 1'b0, cyc, bd, da, ba);
    tests_run++;
    if (cyc != LAT || wlog.size() != NW || wlog[NW-1] !== {18'd262143, expq[NW-1]}) begin
      tests_failed++;
      $display("FAIL back_to_back: cycles=%0d writes=%0d, required %0d %0d ending at 262143",
               cyc, wlog.size(), LAT, NW);
    end
  endtask

  task automatic test_reset_mid_write();
    int cyc, n, logged;
    bit found, bd, da, ba;
    build_expected();
    wlog.delete();
    @(negedge Clock);
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(posedge Clock);
      #1;
      n++;
      if (SRAM_we_n === 1'b0 && SRAM_address === RB + 18'd7) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL reach_wr1_pair2: write to %0d not seen within 200 cycles", RB + 18'd7);
    end
    Resetn = 1'b0;
    #1;
    tests_run++;
    if (SRAM_we_n !== 1'b1 || Busy !== 1'b0 || SRAM_address !== 18'd0 || Done !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: we_n=%b Busy=%b addr=%0d Done=%b, required 1 0 0 0",
               SRAM_we_n, Busy, SRAM_address, Done);
    end
    logged = wlog.size();
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (20) @(posedge Clock);
    #1;
    tests_run++;
    if (wlog.size() != logged) begin
      tests_failed++;
      $display("FAIL no_write_after_reset: %0d writes, required %0d", wlog.size(), logged);
    end
    run_frame(1'b0, 1'b0, cyc, bd, da, ba);
    tests_run++;
    if (cyc != LAT || wlog.size() != NW) begin
      tests_failed++;
      $display("FAIL restart_shape: cycles=%0d writes=%0d, required %0d %0d",
               cyc, wlog.size(), LAT, NW);
    end
    for (int i = 0; i < NW && i < wlog.size(); i++) begin
      tests_run++;
      if (wlog[i] !== {RB + 18'(i), expq[i]}) begin
        tests_failed++;
        $display("FAIL restart_write[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                 i, wlog[i][33:16], wlog[i][15:0], RB + 18'(i), expq[i]);
      end
    end
  endtask

  initial begin
    Resetn = 1'b0;
    Start  = 1'b0;
    test_reset();
    test_fixed_vectors();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
